// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
//   M-stage data-memory access controller: checks store legality, builds the
//   byte enables and write data, and runs the req/ack bus handshake.
//   Optional feature: define MEM_ACCESS_TIMEOUT_EN to enable the bus-wait timeout.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic        m_load,
    input  logic [1:0]  m_store_op,
    input  logic        m_exc_ovstore,
    input  logic        m_flush,
    output logic        m_stall,
    output logic        m_exc_ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [31:0] rdata_q,
    output logic        rdata_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_d;
    logic        rdata_valid_q, rdata_valid_d;

    logic        is_store;
    logic        in_dm, in_t0, in_t1, in_irq, in_timer, in_map;
    logic        misaligned, timer_count;
    logic        start;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;

    assign is_store = (m_store_op != 2'b00);

    assign in_dm    = (m_addr <= 32'h0000_2fff);
    assign in_t0    = (m_addr >= 32'h0000_7f00) && (m_addr <= 32'h0000_7f0b);
    assign in_t1    = (m_addr >= 32'h0000_7f10) && (m_addr <= 32'h0000_7f1b);
    assign in_irq   = (m_addr >= 32'h0000_7f20) && (m_addr <= 32'h0000_7f23);
    assign in_timer = in_t0 || in_t1;
    assign in_map   = in_dm || in_timer || in_irq;

    assign misaligned  = ((m_store_op == 2'b01) && (m_addr[1:0] != 2'b00)) ||
                         ((m_store_op == 2'b10) && m_addr[0]);
    // The timer COUNT register at offset 0x8 is read-only.
    assign timer_count = in_timer && (m_addr[3:2] == 2'b10);

    assign m_exc_ades = is_store && (m_exc_ovstore || misaligned || !in_map ||
                                     (in_timer && (m_store_op != 2'b01)) || timer_count);

    assign start   = (m_load || is_store) && !m_exc_ades && !m_flush;
    assign m_stall = ((state_q == IDLE) && start) || (state_q == REQ);

    always_comb begin
        be_w    = 4'b1111;
        wdata_w = m_wdata;
        case (m_store_op)
            2'b10: begin
                be_w    = m_addr[1] ? 4'b1100 : 4'b0011;
                wdata_w = {m_wdata[15:0], m_wdata[15:0]};
            end
            2'b11: begin
                be_w    = 4'b0001 << m_addr[1:0];
                wdata_w = {4{m_wdata[7:0]}};
            end
            default: begin
                be_w    = 4'b1111;
                wdata_w = m_wdata;
            end
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            timeout;

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic cfg_unused;
    assign cfg_unused = (TIMEOUT < (1 << TO_W));
    assign bus_err    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        bus_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {m_addr[31:2], 2'b00};
                    bus_be_d    = be_w;
                    bus_wdata_d = wdata_w;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end
            end
            REQ: begin
                // Flush is deliberately ignored here: the bus side effect is committed.
                if (bus_ack) begin
                    state_d       = DONE;
                    bus_req_d     = 1'b0;
                    rdata_valid_d = 1'b1;
                    if (!bus_we_q) begin
                        rdata_d = bus_rdata;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (timeout) begin
                    state_d       = DONE;
                    bus_req_d     = 1'b0;
                    rdata_d       = '0;
                    rdata_valid_d = 1'b1;
                    bus_err_d     = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

`default_nettype wire
